// File: rtl/wen_merge_arbiter_pkg.sv
// Shared constants and types for the write-enable merge arbiter.
package wen_merge_pkg;

  localparam int DW_DEF    = 8;
  localparam int NCH_DEF   = 3;
  localparam int DEPTH_DEF = 4;

  typedef logic [1:0]        chan_id_t;
  typedef logic [DW_DEF-1:0] byte_t;

endpackage

// File: rtl/wen_merge_arbiter_if.sv
// Bundle of the per-channel write inputs and the merged output stream.
interface wen_merge_arbiter_if
  import wen_merge_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF
);

  logic [NCH-1:0]    wen;
  logic [NCH*DW-1:0] data;
  logic              freeze;
  logic              ovf_clr;
  logic              o_valid;
  logic              o_ready;
  logic [DW-1:0]     o_data;
  chan_id_t          o_chan;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    empty;

  // Upstream connector / write sink side
  modport master (
    output wen, data, freeze, ovf_clr, o_ready,
    input  o_valid, o_data, o_chan, ovf, empty
  );

  // Arbiter side
  modport slave (
    input  wen, data, freeze, ovf_clr, o_ready,
    output o_valid, o_data, o_chan, ovf, empty
  );

endinterface

// File: rtl/wen_merge_arbiter_chan_fifo.sv
// Per-channel byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module wen_chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;

  // Pointer advance; reset discards contents by realigning pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; a push into a full FIFO lands in the slot being popped this cycle
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/wen_merge_arbiter.sv
// Buffers NCH write channels and merges them round-robin into one registered stream.
module wen_merge_arbiter
  import wen_merge_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic                 clk,
  input logic                 resetn,
  wen_merge_arbiter_if.slave  bus
);

  localparam int unsigned NCH_U = NCH;

  logic [NCH-1:0] full_w, empty_w, push, pop;
  logic [DW-1:0]  rdata [NCH];
  logic [NCH-1:0] ovf_q, ovf_d;
  logic           o_valid_q;
  logic [DW-1:0]  o_data_q;
  chan_id_t       o_chan_q, last_q;
  chan_id_t       gnt_idx, idx;
  logic           gnt_found, free, grant;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    wen_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .wdata_i (bus.data[g*DW +: DW]),
      .rdata_o (rdata[g]),
      .full_o  (full_w[g]),
      .empty_o (empty_w[g])
    );
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NCH_U; k++) begin
      idx = chan_id_t'((32'(last_q) + k) % NCH_U);
      if (!gnt_found && !empty_w[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign free  = !o_valid_q || bus.o_ready;
  assign grant = free && !bus.freeze && gnt_found;

  // Pop the granted FIFO; accept writes when not full or when the slot frees this cycle
  always_comb begin
    pop  = '0;
    push = '0;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      pop[i]  = grant && (gnt_idx == chan_id_t'(i));
      push[i] = bus.wen[i] && (!full_w[i] || pop[i]);
    end
    ovf_d = (bus.ovf_clr ? '0 : ovf_q) | (bus.wen & full_w & ~pop);
  end

  // Output register, round-robin pointer and sticky overflow flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_chan_q  <= '0;
      last_q    <= chan_id_t'(NCH - 1);
      ovf_q     <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (grant) begin
        o_valid_q <= 1'b1;
        o_data_q  <= rdata[gnt_idx];
        o_chan_q  <= gnt_idx;
        last_q    <= gnt_idx;
      end else if (free) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_chan  = o_chan_q;
  assign bus.ovf     = ovf_q;
  assign bus.empty   = empty_w;

endmodule

// File: tb/tb_wen_merge_arbiter.sv
// Directed self-checking bench for wen_merge_arbiter.
module tb_wen_merge_arbiter;
  import wen_merge_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  wen_merge_arbiter_if #(.DW(8), .NCH(3)) bus ();

  wen_merge_arbiter #(.DW(8), .NCH(3), .DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wen     = '0;
    bus.data    = '0;
    bus.freeze  = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.o_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", bus.o_data); end
    n_checks++; if (bus.o_chan !== 2'd0) begin n_fail++; $display("FAIL rst_chan: got %0d expected 0", bus.o_chan); end
    n_checks++; if (bus.ovf !== 3'b000) begin n_fail++; $display("FAIL rst_ovf: got %b expected 000", bus.ovf); end
    n_checks++; if (bus.empty !== 3'b111) begin n_fail++; $display("FAIL rst_empty: got %b expected 111", bus.empty); end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.wen  = 3'b010;
    bus.data = {8'h00, 8'h5A, 8'h00};
    tick();
    bus.wen = '0;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1: valid got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.empty !== 3'b101) begin n_fail++; $display("FAIL single_empty: got %b expected 101", bus.empty); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", bus.o_valid); end
    n_checks++; if (bus.o_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h expected 5a", bus.o_data); end
    n_checks++; if (bus.o_chan !== 2'd1) begin n_fail++; $display("FAIL single_chan: got %0d expected 1", bus.o_chan); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: valid got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    byte_t exp_d [3] = '{8'h10, 8'h20, 8'h30};
    do_reset();
    bus.wen  = 3'b111;
    bus.data = {8'h30, 8'h20, 8'h10};
    tick();
    bus.wen = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", i, bus.o_valid); end
      n_checks++; if (bus.o_data !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.o_data, exp_d[i]); end
      n_checks++; if (bus.o_chan !== 2'(i)) begin n_fail++; $display("FAIL b2b_chan[%0d]: got %0d expected %0d", i, bus.o_chan, i); end
    end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: valid got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.empty !== 3'b111) begin n_fail++; $display("FAIL b2b_empty: got %b expected 111", bus.empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.o_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wen  = 3'b001;
      bus.data = {16'h0000, 8'(i + 1)};
      tick();
    end
    bus.wen = '0;
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h01) begin n_fail++; $display("FAIL ovf_hold: valid %0b data %h expected 1/01", bus.o_valid, bus.o_data); end
    n_checks++; if (bus.ovf !== 3'b001) begin n_fail++; $display("FAIL ovf_set: got %b expected 001", bus.ovf); end
    n_checks++; if (bus.empty !== 3'b110) begin n_fail++; $display("FAIL ovf_empty: got %b expected 110", bus.empty); end
    bus.o_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(j) || bus.o_chan !== 2'd0) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: valid %0b data %h chan %0d expected 1/%h/0", j, bus.o_valid, bus.o_data, bus.o_chan, 8'(j));
      end
    end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_end: valid got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.ovf !== 3'b001) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 001", bus.ovf); end
  endtask

  task automatic test_ovf_clr();
    do_reset();
    bus.o_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wen  = 3'b001;
      bus.data = {16'h0000, 8'(i + 1)};
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      bus.wen  = 3'b100;
      bus.data = {8'(8'hC0 + i), 16'h0000};
      tick();
    end
    n_checks++; if (bus.ovf !== 3'b001) begin n_fail++; $display("FAIL clr_pre: got %b expected 001", bus.ovf); end
    bus.wen     = 3'b100;
    bus.data    = {8'hCF, 16'h0000};
    bus.ovf_clr = 1'b1;
    tick();
    bus.wen = '0;
    n_checks++; if (bus.ovf !== 3'b100) begin n_fail++; $display("FAIL clr_setwins: got %b expected 100", bus.ovf); end
    tick();
    bus.ovf_clr = 1'b0;
    n_checks++; if (bus.ovf !== 3'b000) begin n_fail++; $display("FAIL clr_all: got %b expected 000", bus.ovf); end
  endtask

  task automatic test_freeze();
    do_reset();
    bus.o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wen  = 3'b010;
      bus.data = {8'h00, 8'(8'hA1 + i), 8'h00};
      tick();
    end
    bus.wen = '0;
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hA1) begin n_fail++; $display("FAIL frz_pending: valid %0b data %h expected 1/a1", bus.o_valid, bus.o_data); end
    bus.freeze  = 1'b1;
    bus.o_ready = 1'b1;
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL frz_nogrant: valid got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.o_data !== 8'hA1 || bus.o_chan !== 2'd1) begin n_fail++; $display("FAIL frz_hold: data %h chan %0d expected a1/1", bus.o_data, bus.o_chan); end
    n_checks++; if (bus.empty !== 3'b101) begin n_fail++; $display("FAIL frz_empty: got %b expected 101", bus.empty); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL frz_still: valid got %0b expected 0", bus.o_valid); end
    bus.freeze = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(8'hA2 + j)) begin
        n_fail++; $display("FAIL frz_release[%0d]: valid %0b data %h expected 1/%h", j, bus.o_valid, bus.o_data, 8'(8'hA2 + j));
      end
    end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL frz_end: valid got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.wen  = 3'b111;
    bus.data = {8'h33, 8'h22, 8'h11};
    tick();
    bus.data = {8'h66, 8'h55, 8'h44};
    tick();
    bus.wen = '0;
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: valid got %0b expected 1", bus.o_valid); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.empty !== 3'b111) begin n_fail++; $display("FAIL mid_empty: got %b expected 111", bus.empty); end
    n_checks++; if (bus.o_data !== 8'h00 || bus.o_chan !== 2'd0) begin n_fail++; $display("FAIL mid_out: data %h chan %0d expected 00/0", bus.o_data, bus.o_chan); end
    tick();
    resetn = 1'b1;
    tick();
    bus.wen  = 3'b101;
    bus.data = {8'hC2, 8'h00, 8'hC0};
    tick();
    bus.wen = '0;
    tick();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_chan !== 2'd0 || bus.o_data !== 8'hC0) begin
      n_fail++; $display("FAIL mid_prio0: valid %0b chan %0d data %h expected 1/0/c0", bus.o_valid, bus.o_chan, bus.o_data);
    end
    tick();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_chan !== 2'd2 || bus.o_data !== 8'hC2) begin
      n_fail++; $display("FAIL mid_prio2: valid %0b chan %0d data %h expected 1/2/c2", bus.o_valid, bus.o_chan, bus.o_data);
    end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_end: valid got %0b expected 0", bus.o_valid); end
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_overflow();
    test_ovf_clr();
    test_freeze();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wen_merge_arbiter.md
# wen_merge_arbiter

Consumer of the per-channel write strobes and data bytes that the top-level connector interface fans out (`wen[n]`, `i_dataN`). Buffers each of three byte-wide write channels in a small FIFO and merges them, round-robin, into a single registered valid/ready output stream tagged with the source channel. It sits directly downstream of the connector and feeds the shared write sink. Overflow is reported per channel, and a `freeze` input stalls the merge without losing writes.

## Interface
- `DW`, 8, data width per channel
- `NCH`, 3, number of write channels (2..4)
- `DEPTH`, 4, per-channel FIFO depth, power of two, ≥2
- `clk` in 1, single clock, rising edge
- `resetn` in 1, asynchronous active-low reset
- `wen` in NCH, per-channel write strobe, one byte per high cycle
- `data` in NCH*DW, channel i at bits [i*DW +: DW]
- `freeze` in 1, when high no new grants are made
- `ovf_clr` in 1, clears all `ovf` bits
- `o_valid` out 1, output byte valid
- `o_ready` in 1, sink accepts when `o_valid && o_ready`
- `o_data` out DW, merged byte
- `o_chan` out 2, source channel of `o_data`
- `ovf` out NCH, sticky per-channel overflow flag
- `empty` out NCH, per-channel FIFO empty status

## Operation
- Reset values: all FIFOs empty; `o_valid`=0, `o_data`=0, `o_chan`=0, `ovf`=0, `empty`=all ones; round-robin pointer `last`=NCH-1, so channel 0 has first priority.
- Write, channel i: `wen[i]` high and FIFO not full → push `data[i]`. If the FIFO is full but popped the same cycle → push still accepted. If full with no pop → byte dropped and `ovf[i]` set.
- `ovf_clr` clears all bits; when a new overflow occurs in the same cycle, the set wins for that channel.
- Output register "free" = `!o_valid || o_ready`.
- Grant: when free, `freeze`=0 and at least one FIFO is non-empty, select the first non-empty channel searching from `last+1` mod NCH upward. Pop it, load `o_data`/`o_chan`, set `o_valid`=1, `last`=granted channel.
- Free, with no grant (no data or `freeze`) → `o_valid` drops to 0 and `o_data`/`o_chan` hold their old value.
- `o_valid && !o_ready` → `o_valid`, `o_data` and `o_chan` hold stable; no pop.
- `freeze` high: the pending output still completes its handshake. FIFOs keep accepting writes, and overflow rules are unchanged.
- Per-channel order is preserved. Across channels, round-robin is fair: with all channels busy the grant order is 0,1,2,0,…
- Reset mid-operation: all buffered and pending bytes are discarded immediately. Outputs go to their reset values asynchronously.

## Timing
- A byte written at edge T is visible as non-empty after T. It can be granted at edge T+1, so `o_valid` is high in the cycle after T+1: 2-cycle latency from `wen` to `o_valid`.
- Throughput: one byte per cycle while `o_ready`=1 and data is available. No bubble between back-to-back grants.
- All outputs are registered; there is no combinational path from `wen`/`data` to the outputs. `o_valid` depends combinationally only on registered state.
- `empty` reflects the FIFO state after the last edge.

## Structure
- Shared package `wen_merge_pkg`: `DW_DEF`, `NCH_DEF`, `DEPTH_DEF` constants, typedef `chan_id_t` (logic [1:0]), typedef `byte_t` (logic [DW_DEF-1:0]).
- Sub-module `wen_chan_fifo` is instantiated NCH times. It has push, pop, full and empty, a ptr+1 wrap-bit occupancy, and no internal bypass.
- The top level holds the round-robin arbiter, the output register and the `ovf` flags.

## Test plan
- Reset, then `wen[1]`=1 with `data[1]`=0x5A for one cycle, `o_ready`=1 → `o_valid` high exactly 2 cycles later with `o_data`=0x5A, `o_chan`=1, single pulse.
- All three channels write 0x10/0x20/0x30 in the same cycle, `o_ready`=1 → outputs 0x10(ch0), 0x20(ch1), 0x30(ch2) on consecutive cycles.
- `o_ready`=0, channel 0 written 6 times (0x01..0x06) → the output register takes 0x01, the FIFO holds 0x02..0x05, 0x06 is dropped and `ovf[0]`=1. Raise `o_ready` → exactly 0x01..0x05 drain in order.
- `ovf[0]`=1, pulse `ovf_clr` while a new channel 2 overflow occurs → `ovf`=3'b100.
- `freeze`=1 with ch1 holding 2 bytes and `o_valid` pending → the pending byte completes, then no grant. Release `freeze` → the remaining bytes emerge.
- Assert `resetn`=0 mid-burst → `o_valid`=0 and `empty`=3'b111 immediately. After release, the first new write emerges with `o_chan` starting from channel 0 priority.
